// File: rtl/heap_arbiter_pkg.sv
// Shared types and helpers for the heap port arbiter.
package heap_arbiter_pkg;

  localparam int DefMemoryElementWidth = 12;
  localparam int DefNHeap              = 12;
  localparam int MaxReq                = 8;
  localparam int PtrW                  = 3;

  typedef enum logic {IDLE, LOCKED} state_t;

  typedef struct packed {
    logic            found;
    logic [PtrW-1:0] idx;
  } pick_t;

  // First set bit of valid at or after pointer, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MaxReq-1:0] valid,
                                    input logic [PtrW-1:0]   pointer,
                                    input int                n);
    pick_t r;
    int    j;
    r = '0;
    // Walk from the farthest offset down so the nearest hit wins.
    for (int k = MaxReq-1; k >= 0; k--) begin
      if (k < n) begin
        j = (int'(pointer) + k) % n;
        if (valid[j[PtrW-1:0]]) begin
          r.found = 1'b1;
          r.idx   = j[PtrW-1:0];
        end
      end
    end
    return r;
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] idx,
                                              input int              n);
    return (int'(idx) + 1 >= n) ? '0 : idx + PtrW'(1);
  endfunction

endpackage

// File: rtl/heap_arbiter_if.sv
// Requester bus plus heap memory port seen by the arbiter.
interface heap_arbiter_if #(
  parameter int NReq               = 2,
  parameter int MemoryElementWidth = 12,
  parameter int NHeap              = 12
);
  logic [NReq-1:0]                         reqValid;
  logic [NReq-1:0]                         reqWrite;
  logic [NReq-1:0][NHeap-1:0]              reqAddress;
  logic [NReq-1:0][MemoryElementWidth-1:0] reqData;
  logic [NReq-1:0]                         reqLock;
  logic [NReq-1:0]                         grant;
  logic [NReq-1:0]                         respValid;
  logic [MemoryElementWidth-1:0]           respData;
  logic                                    lockError;
  logic                                    heapWrite;
  logic [NHeap-1:0]                        heapAddress;
  logic [MemoryElementWidth-1:0]           heapIn;
  logic [MemoryElementWidth-1:0]           heapOut;

  // Requesters and heap memory side.
  modport master (
    output reqValid, reqWrite, reqAddress, reqData, reqLock, heapOut,
    input  grant, respValid, respData, lockError, heapWrite, heapAddress, heapIn
  );

  // Arbiter side.
  modport slave (
    input  reqValid, reqWrite, reqAddress, reqData, reqLock, heapOut,
    output grant, respValid, respData, lockError, heapWrite, heapAddress, heapIn
  );
endinterface

// File: rtl/heap_arbiter_rr_priority_pick.sv
// Combinational rotate-priority encoder: winner index at or after pointer.
module rr_priority_pick
  import heap_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]    valid,
  input  logic [PtrW-1:0] pointer,
  output logic            found,
  output logic [PtrW-1:0] idx
);
  logic [MaxReq-1:0] v8;
  pick_t             p;

  // Widen to the helper's fixed width and pick.
  always_comb begin
    v8        = '0;
    v8[N-1:0] = valid;
    p         = rr_pick(v8, pointer, N);
    found     = p.found;
    idx       = p.idx;
  end
endmodule

// File: rtl/heap_arbiter.sv
// Round-robin arbiter sharing a single-port registered-read heap.
// Optional lock/watchdog for read-modify-write: define HEAP_ARBITER_LOCK_EN.
module heap_arbiter
  import heap_arbiter_pkg::*;
#(
  parameter int NReq               = 2,
  parameter int MemoryElementWidth = DefMemoryElementWidth,
  parameter int NHeap              = DefNHeap,
  parameter int LockLimit          = 16
) (
  input logic           clock,
  input logic           reset,
  heap_arbiter_if.slave bus
);
  localparam int CntW = $clog2(LockLimit + 1);

  logic [PtrW-1:0]               pointer, pick_ptr, win_idx, owner;
  logic                          win_found, locked, lk_release, lock_err;
  logic [NReq-1:0]               cand, gnt, resp_q;
  logic                          hw_write;
  logic [NHeap-1:0]              hw_addr, addr_q;
  logic [MemoryElementWidth-1:0] hw_data, data_q;

  // While locked only the owner competes, scanning from its own slot.
  always_comb begin
    cand     = bus.reqValid;
    pick_ptr = pointer;
    if (locked) begin
      pick_ptr = owner;
      for (int i = 0; i < NReq; i++)
        if (PtrW'(i) != owner) cand[i] = 1'b0;
    end
  end

  rr_priority_pick #(.N(NReq)) u_pick (
    .valid   (cand),
    .pointer (pick_ptr),
    .found   (win_found),
    .idx     (win_idx)
  );

  // One-hot grant, forced off while reset is held.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < NReq; i++)
      if (win_found && win_idx == PtrW'(i)) gnt[i] = 1'b1;
    if (!reset) gnt = '0;
  end

  // Heap port follows the winner; address/data hold when nobody wins.
  always_comb begin
    hw_write = 1'b0;
    hw_addr  = addr_q;
    hw_data  = data_q;
    for (int i = 0; i < NReq; i++) begin
      if (gnt[i]) begin
        hw_write = bus.reqWrite[i];
        hw_addr  = bus.reqAddress[i];
        hw_data  = bus.reqData[i];
      end
    end
  end

  // Rotation pointer, read-response strobe and held heap drive values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pointer <= '0;
      resp_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      resp_q <= gnt & ~bus.reqWrite;
      if (|gnt) begin
        addr_q <= hw_addr;
        data_q <= hw_data;
      end
      if ((|gnt && !locked) || lk_release)
        pointer <= ptr_inc(locked ? owner : win_idx, NReq);
    end
  end

`ifdef HEAP_ARBITER_LOCK_EN
  state_t          state, state_n;
  logic [CntW-1:0] lock_cnt;
  logic            win_lock, timeout;

  assign win_lock   = |(gnt & bus.reqLock);
  assign locked     = (state == LOCKED);
  assign lk_release = locked && (state_n == IDLE);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next state: enter on a locking grant, leave on an unlocking owner
  // access or when the watchdog expires (a graceful release wins a tie).
  always_comb begin
    state_n = state;
    timeout = 1'b0;
    case (state)
      IDLE:   if (|gnt && win_lock) state_n = LOCKED;
      LOCKED: begin
        if (|gnt && !win_lock) state_n = IDLE;
        else if (lock_cnt == CntW'(LockLimit - 1)) begin
          state_n = IDLE;
          timeout = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Owner capture, watchdog counter and sticky error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner    <= '0;
      lock_cnt <= '0;
      lock_err <= 1'b0;
    end else begin
      if (!locked && state_n == LOCKED) begin
        owner    <= win_idx;
        lock_cnt <= '0;
      end else if (locked) begin
        lock_cnt <= lock_cnt + CntW'(1);
      end
      if (timeout) lock_err <= 1'b1;
    end
  end
`else
  assign locked     = 1'b0;
  assign lk_release = 1'b0;
  assign owner      = '0;
  assign lock_err   = 1'b0;
`endif

  assign bus.grant       = gnt;
  assign bus.respValid   = resp_q;
  assign bus.respData    = bus.heapOut;
  assign bus.lockError   = lock_err;
  assign bus.heapWrite   = hw_write;
  assign bus.heapAddress = hw_addr;
  assign bus.heapIn      = hw_data;
endmodule

// File: tb/tb_heap_arbiter.sv
// Directed scoreboard bench for heap_arbiter (NReq = 4).
module tb_heap_arbiter;
  localparam int NR = 4;
  localparam int W  = 12;
  localparam int AW = 12;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
  } exp_t;

  logic   clock = 1'b0;
  logic   reset = 1'b0;
  int     checks = 0;
  int     failures = 0;
  exp_t   exp_q[$];
  logic [W-1:0] mem [0:(1<<AW)-1];

  heap_arbiter_if #(.NReq(NR), .MemoryElementWidth(W), .NHeap(AW)) bus ();

  heap_arbiter #(.NReq(NR), .MemoryElementWidth(W), .NHeap(AW), .LockLimit(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Single-port heap model with registered read data.
  always @(posedge clock) begin
    if (bus.heapWrite) mem[bus.heapAddress] <= bus.heapIn;
    bus.heapOut <= mem[bus.heapAddress];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Response monitor: every respValid pulse must match the queue head.
  always @(negedge clock) begin
    exp_t e;
    if (reset && bus.respValid != '0) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 32'(bus.respValid), 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_onehot", 32'(bus.respValid), 32'(1 << e.idx));
        chk("respData", 32'(bus.respData), 32'(e.data));
      end
    end
  end

  task automatic set_rd(input int i, input logic [AW-1:0] a, input logic lk = 1'b0);
    bus.reqValid[i]   = 1'b1;
    bus.reqWrite[i]   = 1'b0;
    bus.reqAddress[i] = a;
    bus.reqData[i]    = '0;
    bus.reqLock[i]    = lk;
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [W-1:0] d,
                        input logic lk = 1'b0);
    bus.reqValid[i]   = 1'b1;
    bus.reqWrite[i]   = 1'b1;
    bus.reqAddress[i] = a;
    bus.reqData[i]    = d;
    bus.reqLock[i]    = lk;
  endtask

  task automatic clr(input int i);
    bus.reqValid[i] = 1'b0;
    bus.reqLock[i]  = 1'b0;
  endtask

  // One cycle: check grant and heap write at negedge, queue the expected
  // read data, then move to just after the next posedge.
  task automatic step(input logic [NR-1:0] eg, input logic [W-1:0] ed = '0);
    @(negedge clock);
    chk("grant", 32'(bus.grant), 32'(eg));
    chk("heapWrite", 32'(bus.heapWrite), 32'(|(eg & bus.reqWrite)));
    for (int i = 0; i < NR; i++)
      if (eg[i] && !bus.reqWrite[i]) exp_q.push_back('{idx: i, data: ed});
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    mem[1] <= 12'd7;
    mem[2] <= 12'd9;
    mem[4] <= 12'd11;
    bus.reqValid   = '1;
    bus.reqWrite   = '0;
    bus.reqAddress = '0;
    bus.reqData    = '0;
    bus.reqLock    = '0;

    // Reset state: no grant even with all requesters valid.
    #12;
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_respValid", 32'(bus.respValid), 32'h0);
    chk("rst_lockError", 32'(bus.lockError), 32'h0);
    bus.reqValid = '0;
    @(posedge clock); #1;
    reset = 1'b1;

    // Single requester: write 5 to addr 3, read it back.
    set_wr(0, 3, 5);  step(4'b0001);
    set_rd(0, 3);     step(4'b0001, 5);
    clr(0);           step(4'b0000);           // pointer = 1

    // Contention between 0 and 1, pointer starts at 1.
    set_rd(0, 1); set_rd(1, 2);
    step(4'b0010, 9); step(4'b0001, 7); step(4'b0010, 9); step(4'b0001, 7);
    clr(0); clr(1);   step(4'b0000);           // pointer = 1

    // Rotation with 4'b1010, wrapping past 3.
    set_rd(1, 1); set_rd(3, 2);
    step(4'b0010, 7); step(4'b1000, 9); step(4'b0010, 7); step(4'b1000, 9);
    clr(1); clr(3);   step(4'b0000);           // pointer = 0

    // Withdrawal: requester 1 loses to 0 then drops without being served.
    set_wr(0, 5, 1); set_rd(1, 1); step(4'b0001);
    clr(0); clr(1);  step(4'b0000);            // pointer = 1

    // Reset in the response cycle of a read.
    set_rd(2, 2);
    @(negedge clock);
    chk("grant_mid", 32'(bus.grant), 32'b0100);
    @(posedge clock); #1;
    chk("resp_before_rst", 32'(bus.respValid), 32'b0100);
    reset = 1'b0;
    #1;
    chk("resp_in_rst", 32'(bus.respValid), 32'h0);
    chk("grant_in_rst", 32'(bus.grant), 32'h0);
    clr(2);
    @(posedge clock); #1;
    reset = 1'b1;
    // Pointer back at 0: requester 1 beats 3.
    set_rd(1, 1); set_rd(3, 2);
    step(4'b0010, 7); step(4'b1000, 9);
    clr(1); clr(3);  step(4'b0000);            // pointer = 0

`ifdef HEAP_ARBITER_LOCK_EN
    // Locked read-modify-write holds off requester 1.
    set_rd(0, 4, 1'b1); set_rd(1, 1);
    step(4'b0001, 11);
    clr(0);             step(4'b0000);
    set_wr(0, 4, 12);   step(4'b0001);
    clr(0);             step(4'b0010, 7);
    clr(1);             step(4'b0000);         // pointer = 2

    // Watchdog: lock then idle for LockLimit cycles.
    set_rd(0, 4, 1'b1); step(4'b0001, 12);
    clr(0); set_rd(1, 1);
    step(4'b0000);
    chk("lockError_early", 32'(bus.lockError), 32'h0);
    repeat (15) step(4'b0000);
    step(4'b0010, 7);
    chk("lockError_set", 32'(bus.lockError), 32'h1);
    clr(1); step(4'b0000); step(4'b0000);
    chk("lockError_sticky", 32'(bus.lockError), 32'h1);
`else
    // Without the lock build reqLock is ignored and never blocks others.
    set_rd(0, 4, 1'b1); set_rd(1, 1);
    step(4'b0001, 11); step(4'b0010, 7);
    clr(0); clr(1); step(4'b0000);
    chk("lockError_off", 32'(bus.lockError), 32'h0);
`endif

    repeat (3) @(posedge clock);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/heap_arbiter.md
Name: heap_arbiter

Overview:
- Shares the single-port heap memory (clk/write/address/in/out, registered read data) between NReq requesters, e.g. interpreter core, array-length updater, free-list manager.
- Round-robin arbitration with a valid/grant handshake.
- Drives the heap port combinationally in the grant cycle and returns read data one cycle later to the granted requester.
- Sits between the program sequencer/helper engines and the heap memory instance.

Parameters:
- NReq, 2, number of requesters (2..8)
- MemoryElementWidth, 12, heap data width
- NHeap, 12, heap address width
- LockLimit, 16, maximum cycles a lock may be held (lock feature only)

Ports:
- clock  input  1  driving clock, all state on posedge
- reset  input  1  asynchronous, active-low reset
- reqValid  input  NReq  requester i wants an access; held until granted
- reqWrite  input  NReq  1 = write, 0 = read
- reqAddress  input  NReq*NHeap  packed addresses, requester i in slice i
- reqData  input  NReq*MemoryElementWidth  packed write data
- reqLock  input  NReq  request to keep ownership after this access (lock feature)
- grant  output  NReq  one-hot, combinational; access is taken at the posedge where grant[i] is high
- respValid  output  NReq  one-hot, registered; read data valid for requester i
- respData  output  MemoryElementWidth  read data, direct from heapOut
- lockError  output  1  sticky; a lock was force-released by the watchdog
- heapWrite  output  1  to heap write
- heapAddress  output  NHeap  to heap address
- heapIn  output  MemoryElementWidth  to heap in
- heapOut  input  MemoryElementWidth  from heap out

Behaviour:
- Reset (reset low, asynchronous): pointer = 0, state = IDLE, respValid = 0, lockError = 0, owner = 0, lockCount = 0. grant is 0 while reset is low.
- Arbitration (IDLE): scan requesters from pointer upward, wrapping modulo NReq; the first with reqValid gets grant. The heap port is driven from the winner in the same cycle.
- With no winner: heapWrite = 0, address and data hold the last value.
- After a granted posedge, pointer = winner + 1 (mod NReq).
- Exactly one grant per cycle; back-to-back grants allowed, giving 1 access per cycle of throughput.
- Reads: respValid[winner] = 1 in the cycle after the grant edge, with respData = heapOut. Writes: no respValid pulse.
- respValid is high for exactly one cycle per read.
- Requester rules: reqWrite, reqAddress, reqData and reqLock must be stable while reqValid is high and ungranted. Dropping reqValid before grant withdraws the request legally.
- Read latency = 1 cycle after grant. A requester may issue its next request in the response cycle.
- Reset mid-operation: pending respValid is cleared and any lock is dropped. Heap contents are untouched.
- NReq = 1: grant = reqValid, no rotation.

Optional Feature:
- Macro: HEAP_ARBITER_LOCK_EN. Used for read-modify-write sequences such as an array-length update.
- With the macro: a granted access with reqLock[i] = 1 moves the FSM to LOCKED with owner = i. In LOCKED only the owner can be granted and pointer does not advance.
- Return to IDLE on either of:
  - an owner access granted with reqLock = 0 (that access is still performed);
  - lockCount reaching LockLimit cycles in LOCKED, which forces IDLE and sets lockError (sticky until reset).
- lockCount resets on entry to LOCKED. After release, pointer = owner + 1.
- Without the macro: reqLock is ignored, the FSM is IDLE only, lockError is tied to 0.

Decomposition:
- Package heap_arbiter_pkg: state enum {IDLE, LOCKED}, default width constants (MemoryElementWidth = 12, NHeap = 12), and a function rr_pick(valid, pointer) returning winner index plus found flag.
- One sub-module is natural: rr_priority_pick, the combinational rotate-priority encoder, reused by any future output-channel arbiter.

Test Plan:
- Single read: requester 0 writes 5 to addr 3, then reads addr 3 -> grant[0] each cycle, respValid[0] one cycle after the read grant, respData = 5.
- Contention: NReq = 2, both valid continuously with reads of addr 1 and addr 2 (holding 7 and 9) -> grants alternate 0,1,0,1; responses alternate 7,9 one cycle behind.
- Rotation fairness: NReq = 4, reqValid = 4'b1010 constant -> grant sequence 1,3,1,3; pointer wraps past 3.
- Withdrawal and reset: requester 1 drops reqValid before grant -> no access and no respValid. Assert reset low mid-read -> respValid = 0 immediately, pointer = 0 after release.
- Lock (HEAP_ARBITER_LOCK_EN): requester 0 reads addr 4 with lock, requester 1 valid throughout, requester 0 writes addr 4 with reqLock = 0 -> requester 1 not granted until after the write edge, then granted.
- Watchdog (HEAP_ARBITER_LOCK_EN): requester 0 locks then idles, with LockLimit = 16 -> forced release after 16 cycles, lockError = 1 and stays 1, requester 1 granted next.
